// File: rtl/ghost_mode_scheduler_if.sv
// Bundle between game-state logic (master) and the ghost mode scheduler (slave).
// The release flags are named release_flags because "release" is a reserved word.
interface ghost_mode_scheduler_if;
  logic       frame_tick;
  logic       level_start;
  logic       energizer_eaten;
  logic       dot_eaten;
  logic [1:0] mode;
  logic       fright_flash;
  logic       reverse_pulse;
  logic [3:0] release_flags;
  logic [2:0] phase_idx;

  modport master (
    output frame_tick, level_start, energizer_eaten, dot_eaten,
    input  mode, fright_flash, reverse_pulse, release_flags, phase_idx
  );

  modport slave (
    input  frame_tick, level_start, energizer_eaten, dot_eaten,
    output mode, fright_flash, reverse_pulse, release_flags, phase_idx
  );
endinterface

// File: rtl/ghost_mode_scheduler.sv
// Global ghost behaviour sequencer: scatter/chase timetable, frightened override,
// reverse commands and ghost-house release ordering.
module ghost_mode_scheduler #(
  parameter int unsigned SCATTER_LONG    = 420,
  parameter int unsigned SCATTER_SHORT   = 300,
  parameter int unsigned CHASE_FRAMES    = 1200,
  parameter int unsigned FRIGHT_FRAMES   = 360,
  parameter int unsigned FLASH_FRAMES    = 120,
  parameter int unsigned INKY_DOT_LIMIT  = 30,
  parameter int unsigned CLYDE_DOT_LIMIT = 60,
  parameter int unsigned RELEASE_TIMEOUT = 240
) (
  input logic                   clk,
  input logic                   reset,
  ghost_mode_scheduler_if.slave bus
);

  localparam int unsigned PHASE_W  = 11;
  localparam int unsigned FRIGHT_W = $clog2(FRIGHT_FRAMES);
  localparam int unsigned IDLE_W   = $clog2(RELEASE_TIMEOUT + 1);
  localparam int unsigned DOT_W    = 7;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FRIGHT = 2'd2;

  localparam logic [1:0] MODE_SCATTER = 2'b00;
  localparam logic [1:0] MODE_FRIGHT  = 2'b10;

  logic [1:0]          state, state_next;
  logic [2:0]          phase_idx, phase_idx_next;
  logic [PHASE_W-1:0]  phase_cnt, phase_cnt_next;
  logic [FRIGHT_W-1:0] fright_cnt, fright_cnt_next;
  logic [DOT_W-1:0]    dot_cnt, dot_cnt_next;
  logic [IDLE_W-1:0]   idle_cnt, idle_cnt_next;
  logic [1:0]          next_ghost, next_ghost_next;
  logic [3:0]          release_flags, release_flags_next;
  logic [1:0]          mode, mode_next;
  logic                fright_flash, fright_flash_next;
  logic                reverse_pulse, reverse_pulse_next;
  logic                limit_hit, timeout_hit;

  // Last phase_cnt value of each timed phase; phase 7 is never timed.
  function automatic logic [PHASE_W-1:0] phase_last(input logic [2:0] p);
    case (p)
      3'd0, 3'd2: return PHASE_W'(SCATTER_LONG - 1);
      3'd4, 3'd6: return PHASE_W'(SCATTER_SHORT - 1);
      default:    return PHASE_W'(CHASE_FRAMES - 1);
    endcase
  endfunction

  function automatic logic [DOT_W-1:0] dot_limit(input logic [1:0] g);
    case (g)
      2'd2:    return DOT_W'(INKY_DOT_LIMIT);
      2'd3:    return DOT_W'(CLYDE_DOT_LIMIT);
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      phase_idx     <= '0;
      phase_cnt     <= '0;
      fright_cnt    <= '0;
      dot_cnt       <= '0;
      idle_cnt      <= '0;
      next_ghost    <= '0;
      release_flags <= '0;
      mode          <= MODE_SCATTER;
      fright_flash  <= 1'b0;
      reverse_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      phase_idx     <= phase_idx_next;
      phase_cnt     <= phase_cnt_next;
      fright_cnt    <= fright_cnt_next;
      dot_cnt       <= dot_cnt_next;
      idle_cnt      <= idle_cnt_next;
      next_ghost    <= next_ghost_next;
      release_flags <= release_flags_next;
      mode          <= mode_next;
      fright_flash  <= fright_flash_next;
      reverse_pulse <= reverse_pulse_next;
    end
  end

  always_comb begin
    state_next         = state;
    phase_idx_next     = phase_idx;
    phase_cnt_next     = phase_cnt;
    fright_cnt_next    = fright_cnt;
    dot_cnt_next       = dot_cnt;
    idle_cnt_next      = idle_cnt;
    next_ghost_next    = next_ghost;
    release_flags_next = release_flags;
    reverse_pulse_next = 1'b0;
    limit_hit          = 1'b0;
    timeout_hit        = 1'b0;

    // Energizer takes priority over a coincident phase-boundary tick.
    case (state)
      ST_IDLE: ;
      ST_RUN: begin
        if (bus.energizer_eaten) begin
          state_next         = ST_FRIGHT;
          fright_cnt_next    = '0;
          reverse_pulse_next = 1'b1;
        end else if (bus.frame_tick) begin
          if (phase_idx != 3'd7) begin
            if (phase_cnt == phase_last(phase_idx)) begin
              phase_idx_next     = phase_idx + 1'b1;
              phase_cnt_next     = '0;
              reverse_pulse_next = 1'b1;
            end else begin
              phase_cnt_next = phase_cnt + 1'b1;
            end
          end else if (phase_cnt != '1) begin
            phase_cnt_next = phase_cnt + 1'b1;
          end
        end
      end
      ST_FRIGHT: begin
        if (bus.energizer_eaten) begin
          fright_cnt_next = '0;
        end else if (bus.frame_tick) begin
          if (fright_cnt == FRIGHT_W'(FRIGHT_FRAMES - 1)) begin
            state_next      = ST_RUN;
            fright_cnt_next = '0;
          end else begin
            fright_cnt_next = fright_cnt + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // House release: a dot-limit hit or an inactivity timeout frees the next ghost.
    if (state != ST_IDLE && !release_flags[3]) begin
      limit_hit   = (dot_cnt >= dot_limit(next_ghost));
      timeout_hit = bus.frame_tick && !bus.dot_eaten &&
                    (idle_cnt == IDLE_W'(RELEASE_TIMEOUT - 1));
      if (bus.dot_eaten) begin
        dot_cnt_next  = dot_cnt + 1'b1;
        idle_cnt_next = '0;
      end else if (bus.frame_tick) begin
        idle_cnt_next = idle_cnt + 1'b1;
      end
      if (limit_hit || timeout_hit) begin
        release_flags_next[next_ghost] = 1'b1;
        next_ghost_next                = next_ghost + 1'b1;
        dot_cnt_next                   = limit_hit ? DOT_W'(bus.dot_eaten) : '0;
        if (timeout_hit) idle_cnt_next = '0;
      end
    end

    if (bus.level_start) begin
      state_next         = ST_RUN;
      phase_idx_next     = '0;
      phase_cnt_next     = '0;
      fright_cnt_next    = '0;
      dot_cnt_next       = '0;
      idle_cnt_next      = '0;
      next_ghost_next    = 2'd1;
      release_flags_next = 4'b0001;
      reverse_pulse_next = 1'b0;
    end

    case (state_next)
      ST_FRIGHT: mode_next = MODE_FRIGHT;
      ST_RUN:    mode_next = {1'b0, phase_idx_next[0]};
      default:   mode_next = MODE_SCATTER;
    endcase
    fright_flash_next = (state_next == ST_FRIGHT) &&
                        (fright_cnt_next >= FRIGHT_W'(FRIGHT_FRAMES - FLASH_FRAMES));
  end

  assign bus.mode          = mode;
  assign bus.fright_flash  = fright_flash;
  assign bus.reverse_pulse = reverse_pulse;
  assign bus.release_flags = release_flags;
  assign bus.phase_idx     = phase_idx;

endmodule
